// File: rtl/aer_pkg.sv
// Shared sizing constants and FSM state encoding for the AER spike arbiter.
package aer_pkg;
  localparam int N_NEURONS = 16;
  localparam int ADDR_W    = 4;
  localparam int TS_W      = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;
endpackage

// File: rtl/aer_spike_arbiter_if.sv
// Address-event output stream: valid/ready handshake carrying neuron index and timestamp.
interface aer_spike_arbiter_if #(
  parameter int ADDR_W = aer_pkg::ADDR_W,
  parameter int TS_W   = aer_pkg::TS_W
) ();
  logic              event_valid;
  logic              event_ready;
  logic [ADDR_W-1:0] event_addr;
  logic [TS_W-1:0]   event_ts;

  modport master (output event_valid, output event_addr, output event_ts, input event_ready);
  modport slave  (input event_valid, input event_addr, input event_ts, output event_ready);
endinterface

// File: rtl/rr_priority_select.sv
// Combinational round-robin search: first set pending bit strictly after last_grant, wrapping.
module rr_priority_select #(
  parameter int N_NEURONS = aer_pkg::N_NEURONS,
  parameter int ADDR_W    = aer_pkg::ADDR_W
) (
  input  logic [N_NEURONS-1:0] pending,
  input  logic [ADDR_W-1:0]    last_grant,
  output logic [ADDR_W-1:0]    winner,
  output logic                 any
);
  logic [ADDR_W-1:0] idx;

  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    for (int k = 1; k <= N_NEURONS; k++) begin
      idx = ADDR_W'((int'(last_grant) + k) % N_NEURONS);
      if (!any && pending[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/aer_spike_arbiter.sv
// Captures one-cycle spike pulses into pending bits and serialises them as round-robin
// address events with a grant-time timestamp; one-cycle ack returned after each handshake.
module aer_spike_arbiter #(
  parameter int N_NEURONS = aer_pkg::N_NEURONS,
  parameter int ADDR_W    = aer_pkg::ADDR_W,
  parameter int TS_W      = aer_pkg::TS_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [N_NEURONS-1:0]   spikes_in,
  aer_spike_arbiter_if.master    ev,
  output logic [N_NEURONS-1:0]   acks_out,
  output logic [7:0]             overflow_cnt
);
  import aer_pkg::*;

  state_t                 state, state_nx;
  logic [N_NEURONS-1:0]   pending, clear, lost;
  logic [ADDR_W-1:0]      last_grant, winner, addr_q;
  logic [TS_W-1:0]        ts_counter, ts_q;
  logic                   any, grant, hs;
  logic [ADDR_W:0]        n_lost;
  logic [8:0]             ov_sum;

  rr_priority_select #(.N_NEURONS(N_NEURONS), .ADDR_W(ADDR_W)) u_rr (
    .pending    (pending),
    .last_grant (last_grant),
    .winner     (winner),
    .any        (any)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    hs       = 1'b0;
    case (state)
      IDLE: if (enable && any) begin
        grant    = 1'b1;
        state_nx = SEND;
      end
      SEND: if (ev.event_ready) begin
        hs       = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // A re-spike on the bit being served this edge simply re-arms it rather than counting as lost.
  always_comb begin
    clear  = hs ? (N_NEURONS'(1) << addr_q) : '0;
    lost   = spikes_in & pending & ~clear;
    n_lost = '0;
    for (int i = 0; i < N_NEURONS; i++) n_lost = n_lost + (ADDR_W+1)'(lost[i]);
    ov_sum = {1'b0, overflow_cnt} + 9'(n_lost);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending      <= '0;
      overflow_cnt <= '0;
      ts_counter   <= '0;
      addr_q       <= '0;
      ts_q         <= '0;
      acks_out     <= '0;
      last_grant   <= ADDR_W'(N_NEURONS - 1);
    end else begin
      pending      <= (pending & ~clear) | spikes_in;
      overflow_cnt <= (ov_sum > 9'd255) ? 8'hFF : ov_sum[7:0];
      ts_counter   <= ts_counter + TS_W'(1);
      acks_out     <= clear;
      if (grant) begin
        addr_q <= winner;
        ts_q   <= ts_counter;
      end
      if (hs) last_grant <= addr_q;
    end
  end

  assign ev.event_valid = (state == SEND);
  assign ev.event_addr  = addr_q;
  assign ev.event_ts    = ts_q;
endmodule

// File: tb/tb_aer_spike_arbiter.sv
// Directed bench for aer_spike_arbiter with an address scoreboard checked at each handshake.
module tb_aer_spike_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] spikes_in = '0;
  logic [15:0] acks_out;
  logic [7:0]  overflow_cnt;

  aer_spike_arbiter_if #(.ADDR_W(4), .TS_W(16)) ev ();

  aer_spike_arbiter #(.N_NEURONS(16), .ADDR_W(4), .TS_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .spikes_in    (spikes_in),
    .ev           (ev.master),
    .acks_out     (acks_out),
    .overflow_cnt (overflow_cnt)
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_pass = 0, n_fail = 0;
  logic [3:0]  exp_q[$];
  bit          mon_en = 1'b0;
  bit          ack_due = 1'b0;
  logic [15:0] ack_exp = '0;
  logic [3:0]  a_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic spike(input logic [15:0] m);
    spikes_in = m;
    tick();
    spikes_in = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    spikes_in = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while ((exp_q.size() != 0 || ev.event_valid) && k < 40) begin
      tick();
      k++;
    end
    chk({tag, "_drained"}, 32'(exp_q.size()), 0);
    repeat (4) tick();
    chk({tag, "_idle"}, 32'(ev.event_valid), 0);
  endtask

  task automatic wait_ack();
    int k = 0;
    while (acks_out == '0 && k < 20) begin
      tick();
      k++;
    end
    chk("ack_seen", 32'(acks_out != '0), 1);
  endtask

  // Scoreboard: a valid&ready seen here completes at the next rising edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (ack_due) begin
        chk("ack_pulse", 32'(acks_out), 32'(ack_exp));
        ack_due = 1'b0;
      end else begin
        chk("ack_quiet", 32'(acks_out), 0);
      end
      if (rst_n && ev.event_valid && ev.event_ready) begin
        chk("event_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          a_exp = exp_q.pop_front();
          chk("event_addr", 32'(ev.event_addr), 32'(a_exp));
          ack_exp = 16'(1) << a_exp;
          ack_due = 1'b1;
        end
      end
    end
  end

  initial begin
    ev.event_ready = 1'b0;
    do_reset();
    chk("rst_valid", 32'(ev.event_valid), 0);
    chk("rst_addr", 32'(ev.event_addr), 0);
    chk("rst_ts", 32'(ev.event_ts), 0);
    chk("rst_acks", 32'(acks_out), 0);
    chk("rst_ovf", 32'(overflow_cnt), 0);
    mon_en = 1'b1;

    // Single spike, latency and timestamp.
    do_reset();
    enable = 1'b1;
    ev.event_ready = 1'b1;
    exp_q.push_back(4'd3);
    spike(16'h0008);
    chk("lat_not_yet", 32'(ev.event_valid), 0);
    tick();
    chk("lat_valid", 32'(ev.event_valid), 1);
    chk("single_addr", 32'(ev.event_addr), 3);
    chk("single_ts", 32'(ev.event_ts), 1);
    drain("single");

    // Simultaneous spikes on 0 and 15.
    do_reset();
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd15);
    spike(16'h8001);
    drain("simul");
    chk("simul_ovf", 32'(overflow_cnt), 0);

    // Fairness between 2 and 5 under continuous re-spiking.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(4'd2);
      exp_q.push_back(4'd5);
    end
    spike(16'h0024);
    for (int i = 0; i < 4; i++) begin
      wait_ack();
      spike((i % 2 == 0) ? 16'h0004 : 16'h0020);
    end
    drain("fair");

    // Backpressure with a lost spike.
    do_reset();
    ev.event_ready = 1'b0;
    spike(16'h0010);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 32'(ev.event_valid), 1);
      chk("bp_addr", 32'(ev.event_addr), 4);
      chk("bp_ts", 32'(ev.event_ts), 1);
      if (i == 4) spike(16'h0010);
      else        tick();
    end
    chk("bp_ovf", 32'(overflow_cnt), 1);
    exp_q.push_back(4'd4);
    ev.event_ready = 1'b1;
    drain("bp");

    // Enable low blocks grants; dropping it during SEND does not withdraw the event.
    do_reset();
    enable = 1'b0;
    ev.event_ready = 1'b0;
    spike(16'h0001);
    repeat (3) tick();
    chk("en_block", 32'(ev.event_valid), 0);
    enable = 1'b1;
    tick();
    chk("en_grant", 32'(ev.event_valid), 1);
    enable = 1'b0;
    tick();
    chk("en_hold", 32'(ev.event_valid), 1);
    exp_q.push_back(4'd0);
    ev.event_ready = 1'b1;
    drain("en");
    enable = 1'b1;

    // Reset while an event is in flight.
    do_reset();
    ev.event_ready = 1'b0;
    spike(16'h0002);
    tick();
    chk("mid_valid_before", 32'(ev.event_valid), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_valid", 32'(ev.event_valid), 0);
    chk("mid_acks", 32'(acks_out), 0);
    spike(16'h0040);
    tick();
    chk("mid_addr", 32'(ev.event_addr), 6);
    chk("mid_ts_restart", 32'(ev.event_ts), 1);
    exp_q.push_back(4'd6);
    ev.event_ready = 1'b1;
    drain("mid");

    // Timestamp wrap, then overflow saturation.
    ev.event_ready = 1'b0;
    do_reset();
    repeat (65535) tick();
    spike(16'h0008);
    tick();
    chk("wrap_valid", 32'(ev.event_valid), 1);
    chk("wrap_ts", 32'(ev.event_ts), 0);
    for (int i = 1; i <= 300; i++) begin
      spike(16'h0008);
      if (i == 254) chk("ovf_254", 32'(overflow_cnt), 254);
      if (i == 255) chk("ovf_255", 32'(overflow_cnt), 255);
    end
    chk("ovf_sat", 32'(overflow_cnt), 255);
    exp_q.push_back(4'd3);
    ev.event_ready = 1'b1;
    drain("wrap");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/aer_spike_arbiter.md
AER_SPIKE_ARBITER -- requirements
Module: aer_spike_arbiter

Interface
- REQ-001 Parameter N_NEURONS, default 16: number of spike requesters.
- REQ-002 Parameter ADDR_W, default 4: event address width, equal to log2(N_NEURONS).
- REQ-003 Parameter TS_W, default 16: timestamp width.
- REQ-004 clk  in  1  single clock; all logic on rising edge.
- REQ-005 rst_n  in  1  reset, synchronous, active-low.
- REQ-006 enable  in  1  when low, no new grants; spike capture continues.
- REQ-007 spikes_in  in  N_NEURONS  one-cycle spike pulses, one bit per neuron.
- REQ-008 event_valid  out  1  address event available.
- REQ-009 event_ready  in  1  downstream accepts the event.
- REQ-010 event_addr  out  ADDR_W  index of the granted neuron.
- REQ-011 event_ts  out  TS_W  timestamp captured at grant.
- REQ-012 acks_out  out  N_NEURONS  one-hot, one-cycle ack to the served neuron.
- REQ-013 overflow_cnt  out  8  saturating count of lost spikes.

Function
- REQ-014 A spikes_in bit high at edge t sets pending[i] after edge t.
- REQ-015 A spike on a bit whose pending is already set, and not being cleared that edge, increments overflow_cnt, saturating at 255.
- REQ-016 FSM has two states, IDLE and SEND.
- REQ-017 IDLE: if enable=1 and pending is nonzero, latch the round-robin winner into event_addr, latch ts_counter into event_ts, and go to SEND.
- REQ-018 Round-robin winner: the first set pending bit searching upward from last_grant+1, modulo N_NEURONS; last_grant resets to N_NEURONS-1, so bit 0 has first priority.
- REQ-019 SEND: event_valid=1; event_addr and event_ts stay stable until handshake.
- REQ-020 Handshake occurs when event_valid=1 and event_ready=1 at an edge.
- REQ-021 On handshake:
  - clear pending[event_addr];
  - pulse acks_out[event_addr] for exactly the next cycle;
  - set last_grant=event_addr;
  - return to IDLE.
- REQ-022 A new spike on the same bit at the handshake edge leaves pending set; this is not an overflow.
- REQ-023 Latency: spike at edge t gives event_valid high from edge t+2, with no backpressure.
- REQ-024 Maximum throughput is one event per 2 cycles.
- REQ-025 enable falling while in SEND does not withdraw the event; it completes normally.
- REQ-026 ts_counter is a free-running TS_W-bit counter, +1 per cycle, wrapping to 0.
- REQ-027 acks_out is zero except in the cycle after a handshake.

Reset
- REQ-028 With rst_n=0 at an edge, clear the following:
  - pending, overflow_cnt, ts_counter, event_addr, event_ts, acks_out and event_valid go to 0;
  - FSM goes to IDLE;
  - last_grant goes to N_NEURONS-1.
- REQ-029 Reset mid-SEND drops the in-flight event silently with no ack.
- REQ-030 Spikes present during reset are not captured.

Structure
- REQ-031 N_NEURONS, ADDR_W, TS_W and the FSM state enum live in shared package aer_pkg.
- REQ-032 Winner search is a combinational sub-module, rr_priority_select (inputs: pending, last_grant; outputs: winner index, any).

Verification
- REQ-033 Single spike: spikes_in=0x0008 at t, event_ready=1 -> event_valid at t+2, event_addr=3, acks_out=0x0008 one cycle after handshake.
- REQ-034 Simultaneous spikes: spikes_in=0x8001 once, ready=1 -> events with addr 0 then 15, then addr 15 again never appears.
- REQ-035 Fairness: bits 2 and 5 re-spike after each ack -> grants alternate 2,5,2,5.
- REQ-036 Backpressure: event_ready=0 for 10 cycles -> event_valid held, event_addr/event_ts constant; a second spike on the same bit increments overflow_cnt to 1.
- REQ-037 Reset mid-SEND: rst_n=0 one cycle while valid -> event_valid=0, pending=0, acks_out=0 next cycle; ts_counter restarts at 0.
- REQ-038 Wrap and saturation: run ts_counter past 0xFFFF -> event_ts captured as 0x0000; 300 overflows -> overflow_cnt=255.
